// File: rtl/cas_buf_arb.sv
// Cassette image buffer arbiter: serialises HPS loader writes and playback
// reads onto one SRAM port, tracks tape length and answers end-of-tape reads.
//
// state   | meaning
// IDLE    | port free; issue a held write first, otherwise accept a read
// WR      | write cycle on the SRAM port, we high for exactly one cycle
// RD_WAIT | address issued, counting down the SRAM read latency
// RD_DONE | sram_dout valid; capture it and pulse rd_ack
module cas_buf_arb #(
    parameter int SRAM_LAT = 1,
    parameter int AW       = 16
) (
    input  logic          clk_sys,
    input  logic          COCO_RESET_N,
    input  logic          ioctl_download,
    input  logic          load_sel,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          rd_ack,
    output logic          rd_eot,
    output logic [AW-1:0] sram_addr,
    output logic          sram_we,
    output logic [7:0]    sram_din,
    input  logic [7:0]    sram_dout,
    output logic [AW:0]   tape_len,
    output logic          tape_ready,
    output logic          wr_overrun
);

    localparam int CW = $clog2(SRAM_LAT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_valid_q, hold_valid_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic [AW-1:0] sram_addr_q, sram_addr_d;
    logic          sram_we_q, sram_we_d;
    logic [7:0]    sram_din_q, sram_din_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_ack_q, rd_ack_d;
    logic          rd_eot_q, rd_eot_d;
    logic [AW:0]   tape_len_q, tape_len_d;
    logic          tape_ready_q, tape_ready_d;
    logic          wr_overrun_q, wr_overrun_d;
    logic          dl_sel_q, dl_sel_d;

    logic          dl_rise, dl_fall, wr_fire, wr_oob, wr_accept;
    logic [AW:0]   wr_len;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        sram_addr_d  = sram_addr_q;
        sram_we_d    = 1'b0;
        sram_din_d   = sram_din_q;
        rd_data_d    = rd_data_q;
        rd_ack_d     = 1'b0;
        rd_eot_d     = 1'b0;
        tape_len_d   = tape_len_q;
        tape_ready_d = tape_ready_q;
        wr_overrun_d = wr_overrun_q;

        dl_sel_d  = ioctl_download & load_sel;
        dl_rise   = dl_sel_d & ~dl_sel_q;
        dl_fall   = dl_sel_q & ~ioctl_download;
        wr_fire   = dl_sel_d & ioctl_wr;
        wr_oob    = |ioctl_addr[24:AW];
        wr_accept = wr_fire & ~wr_oob & ~hold_valid_q;
        wr_len    = {1'b0, ioctl_addr[AW-1:0]} + (AW+1)'(1);

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    sram_addr_d  = hold_addr_q;
                    sram_din_d   = hold_data_q;
                    sram_we_d    = 1'b1;
                    hold_valid_d = 1'b0;
                    state_d      = WR;
                end else if (rd_req && tape_ready_q && !rd_ack_q) begin
                    // A request still high during its own ack cycle is the old one.
                    if ({1'b0, rd_addr} >= tape_len_q) begin
                        rd_ack_d  = 1'b1;
                        rd_eot_d  = 1'b1;
                        rd_data_d = 8'h00;
                    end else begin
                        sram_addr_d = rd_addr;
                        cnt_d       = CW'(SRAM_LAT);
                        state_d     = RD_WAIT;
                    end
                end
            end
            WR: state_d = IDLE;
            RD_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = RD_DONE;
            end
            RD_DONE: begin
                rd_data_d = sram_dout;
                rd_ack_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (dl_rise) begin
            tape_len_d   = '0;
            tape_ready_d = 1'b0;
            wr_overrun_d = 1'b0;
        end
        if (dl_fall) tape_ready_d = (tape_len_q != '0);

        if (wr_fire && (wr_oob || hold_valid_q)) wr_overrun_d = 1'b1;
        if (wr_accept) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = ioctl_addr[AW-1:0];
            hold_data_d  = ioctl_data;
            // Compare against tape_len_d so a write on the start edge sees the cleared length.
            if (wr_len > tape_len_d) tape_len_d = wr_len;
        end
    end

    always_ff @(posedge clk_sys or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            sram_addr_q  <= '0;
            sram_we_q    <= 1'b0;
            sram_din_q   <= '0;
            rd_data_q    <= '0;
            rd_ack_q     <= 1'b0;
            rd_eot_q     <= 1'b0;
            tape_len_q   <= '0;
            tape_ready_q <= 1'b0;
            wr_overrun_q <= 1'b0;
            dl_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            sram_addr_q  <= sram_addr_d;
            sram_we_q    <= sram_we_d;
            sram_din_q   <= sram_din_d;
            rd_data_q    <= rd_data_d;
            rd_ack_q     <= rd_ack_d;
            rd_eot_q     <= rd_eot_d;
            tape_len_q   <= tape_len_d;
            tape_ready_q <= tape_ready_d;
            wr_overrun_q <= wr_overrun_d;
            dl_sel_q     <= dl_sel_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_ack     = rd_ack_q;
    assign rd_eot     = rd_eot_q;
    assign sram_addr  = sram_addr_q;
    assign sram_we    = sram_we_q;
    assign sram_din   = sram_din_q;
    assign tape_len   = tape_len_q;
    assign tape_ready = tape_ready_q;
    assign wr_overrun = wr_overrun_q;

endmodule

// File: tb/tb_cas_buf_arb.sv
// Directed bench for cas_buf_arb: behavioural one-cycle SRAM, table of reads
// after a basic load, plus hand-written collision, bounds and reset sequences.
module tb_cas_buf_arb;

    logic        clk_sys = 1'b0;
    logic        COCO_RESET_N;
    logic        ioctl_download, load_sel, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_ack, rd_eot;
    logic [15:0] sram_addr;
    logic        sram_we;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;
    logic [16:0] tape_len;
    logic        tape_ready, wr_overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem [0:65535];

    always #5 clk_sys = ~clk_sys;

    cas_buf_arb #(.SRAM_LAT(1), .AW(16)) dut (
        .clk_sys(clk_sys), .COCO_RESET_N(COCO_RESET_N),
        .ioctl_download(ioctl_download), .load_sel(load_sel), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
        .rd_eot(rd_eot), .sram_addr(sram_addr), .sram_we(sram_we), .sram_din(sram_din),
        .sram_dout(sram_dout), .tape_len(tape_len), .tape_ready(tape_ready),
        .wr_overrun(wr_overrun)
    );

    // Synchronous SRAM, one cycle read latency
    always @(posedge clk_sys) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ioctl_wr in cycle N; if chk, sram_we must appear in cycle N+2
    task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input bit chk);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
        step();
        ioctl_wr = 1'b0;
        step();
        if (chk) begin
            check("wr_we", 32'(sram_we), 32'd1);
            check("wr_addr", 32'(sram_addr), 32'(a[15:0]));
            check("wr_din", 32'(sram_din), 32'(d));
        end
        repeat (6) step();
    endtask

    task automatic do_read(input string nm, input logic [15:0] a,
                           input logic [7:0] exp_d, input bit exp_eot);
        int lat;
        logic [15:0] addr_before;
        addr_before = sram_addr;
        rd_req = 1'b1; rd_addr = a;
        lat = 0;
        while (!rd_ack && lat < 20) begin
            step();
            lat++;
        end
        rd_req = 1'b0;
        check({nm, "_lat"}, 32'(lat), exp_eot ? 32'd1 : 32'd3);
        check({nm, "_data"}, 32'(rd_data), 32'(exp_d));
        check({nm, "_eot"}, 32'(rd_eot), 32'(exp_eot));
        if (exp_eot) check({nm, "_noaddr"}, 32'(sram_addr), 32'(addr_before));
        step();
        check({nm, "_single"}, 32'(rd_ack), 32'd0);
        step();
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          eot;
    } rd_vec_t;

    initial begin
        rd_vec_t vecs [6];
        int acks;
        vecs[0] = '{16'h0002, 8'h33, 1'b0};
        vecs[1] = '{16'h0000, 8'h11, 1'b0};
        vecs[2] = '{16'h0003, 8'h44, 1'b0};
        vecs[3] = '{16'h0004, 8'h00, 1'b1};
        vecs[4] = '{16'h0001, 8'h22, 1'b0};
        vecs[5] = '{16'h0100, 8'h00, 1'b1};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        COCO_RESET_N = 1'b0;
        ioctl_download = 1'b0; load_sel = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_data = '0; rd_req = 1'b0; rd_addr = '0;
        repeat (3) step();
        check("rst_rd_ack", 32'(rd_ack), 32'd0);
        check("rst_sram_we", 32'(sram_we), 32'd0);
        check("rst_tape_len", 32'(tape_len), 32'd0);
        check("rst_tape_ready", 32'(tape_ready), 32'd0);
        COCO_RESET_N = 1'b1;
        step();

        // Basic load
        ioctl_download = 1'b1; load_sel = 1'b1;
        step();
        write_byte(25'h0, 8'h11, 1'b1);
        write_byte(25'h1, 8'h22, 1'b1);
        write_byte(25'h2, 8'h33, 1'b1);
        write_byte(25'h3, 8'h44, 1'b1);
        check("load_len", 32'(tape_len), 32'd4);
        check("load_ready_during", 32'(tape_ready), 32'd0);
        ioctl_download = 1'b0;
        step();
        check("load_ready", 32'(tape_ready), 32'd1);
        load_sel = 1'b0;
        step();

        for (int i = 0; i < 6; i++) do_read($sformatf("rd%0d", i), vecs[i].addr, vecs[i].data, vecs[i].eot);

        // Collision: write arrives one cycle after the read is accepted
        rd_req = 1'b1; rd_addr = 16'h0001;
        step();
        ioctl_download = 1'b1; load_sel = 1'b1;
        ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_data = 8'hAA;
        step();
        ioctl_wr = 1'b0;
        step();
        check("col_ack", 32'(rd_ack), 32'd1);
        check("col_data", 32'(rd_data), 32'h22);
        rd_req = 1'b0;
        step();
        check("col_we", 32'(sram_we), 32'd1);
        check("col_addr", 32'(sram_addr), 32'h10);
        check("col_din", 32'(sram_din), 32'hAA);
        check("col_noack", 32'(rd_ack), 32'd0);
        check("col_overrun", 32'(wr_overrun), 32'd0);
        ioctl_download = 1'b0;
        step();
        check("col_len", 32'(tape_len), 32'h11);
        check("col_ready", 32'(tape_ready), 32'd1);
        load_sel = 1'b0;
        step();
        do_read("col_rd", 16'h0010, 8'hAA, 1'b0);

        // Bounds
        ioctl_download = 1'b1; load_sel = 1'b1;
        step();
        check("bnd_len_clear", 32'(tape_len), 32'd0);
        write_byte(25'h5, 8'h55, 1'b1);
        check("bnd_len6", 32'(tape_len), 32'd6);
        write_byte(25'h10000, 8'h66, 1'b0);
        check("bnd_oob_overrun", 32'(wr_overrun), 32'd1);
        check("bnd_oob_len", 32'(tape_len), 32'd6);
        write_byte(25'hFFFF, 8'h77, 1'b1);
        check("bnd_len_max", 32'(tape_len), 32'h10000);
        ioctl_download = 1'b0;
        step();
        check("bnd_ready", 32'(tape_ready), 32'd1);
        ioctl_download = 1'b1;
        step();
        check("bnd_overrun_clear", 32'(wr_overrun), 32'd0);
        check("bnd_ready_clear", 32'(tape_ready), 32'd0);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0; ioctl_data = 8'h5A;
        step();
        ioctl_addr = 25'h1; ioctl_data = 8'hA5;
        step();
        ioctl_wr = 1'b0;
        repeat (4) step();
        check("bnd_dbl_overrun", 32'(wr_overrun), 32'd1);
        check("bnd_dbl_len", 32'(tape_len), 32'd1);
        ioctl_download = 1'b0;
        step();
        load_sel = 1'b0;
        step();
        do_read("bnd_rd0", 16'h0000, 8'h5A, 1'b0);
        do_read("bnd_rd1", 16'h0001, 8'h00, 1'b1);

        // Reset while in RD_WAIT
        rd_req = 1'b1; rd_addr = 16'h0000;
        step();
        COCO_RESET_N = 1'b0;
        #1;
        check("rst2_sram_addr", 32'(sram_addr), 32'd0);
        check("rst2_rd_data", 32'(rd_data), 32'd0);
        check("rst2_tape_len", 32'(tape_len), 32'd0);
        check("rst2_overrun", 32'(wr_overrun), 32'd0);
        check("rst2_ack", 32'(rd_ack), 32'd0);
        step();
        COCO_RESET_N = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_ack) acks++;
        end
        check("rst2_no_ack", 32'(acks), 32'd0);
        rd_req = 1'b0;
        step();

        // New load after reset restores service
        ioctl_download = 1'b1; load_sel = 1'b1;
        step();
        write_byte(25'h0, 8'hC3, 1'b1);
        ioctl_download = 1'b0;
        step();
        load_sel = 1'b0;
        step();
        do_read("rst2_rd", 16'h0000, 8'hC3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cas_buf_arb.md
# cas_buf_arb

Arbiter and sequencer for the cassette image buffer (single-port synchronous SRAM, 64 KB) that sits between the HPS loader (`ioctl_*`, tape index) and the cassette playback engine. It serialises loader writes and playback reads onto the one SRAM port, giving writes priority. It tracks the loaded tape length and answers reads past end-of-tape without touching the SRAM. It replaces the ad-hoc address mux in the top level.

## Interface
Parameters:
- `SRAM_LAT`, 1: SRAM read latency, in clk_sys cycles, from `sram_addr` registered to `sram_dout` valid.
- `AW`, 16: SRAM address width.

Ports:
- `clk_sys` in 1: system clock; all logic on the rising edge.
- `COCO_RESET_N` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: HPS transfer in progress.
- `load_sel` in 1: current transfer is a tape image (`ioctl_index`==2, decoded by the top level).
- `ioctl_wr` in 1: one-cycle write strobe from hps_io.
- `ioctl_addr` in 25: loader byte address.
- `ioctl_data` in 8: loader byte.
- `rd_req` in 1: playback read request; level, held until `rd_ack`.
- `rd_addr` in AW: playback byte address; stable while `rd_req` is high.
- `rd_data` out 8: read byte; valid when `rd_ack` is high.
- `rd_ack` out 1: one-cycle completion pulse.
- `rd_eot` out 1: qualifies `rd_ack`; the address was at or beyond end of tape.
- `sram_addr` out AW: SRAM address (registered).
- `sram_we` out 1: SRAM write enable, active high (registered). The top level inverts it for `COCO_SRAM` R_W.
- `sram_din` out 8: SRAM write data (registered).
- `sram_dout` in 8: SRAM read data.
- `tape_len` out AW+1: number of bytes loaded (0..65536).
- `tape_ready` out 1: an image is loaded and no download is active.
- `wr_overrun` out 1: sticky; a loader write was lost.

## Operation
- **Loader capture.** When `ioctl_download & load_sel & ioctl_wr` is true, the byte is captured into a one-entry hold register (address, data, valid).
  - If `ioctl_addr[24:AW]`≠0, the write is discarded and `wr_overrun` is set.
  - If the hold register is already valid, the new write is discarded and `wr_overrun` is set.
- **Download start.** On the rising edge of `ioctl_download & load_sel`:
  - `tape_len` is set to 0 and `tape_ready` to 0.
  - `wr_overrun` is cleared.
  - A write captured in the same cycle is kept.
- **Length tracking.** Each accepted write updates `tape_len` to max(`tape_len`, addr+1). The result is 17 bits, so address 0xFFFF gives 65536.
- **Download end.** On the falling edge of `ioctl_download` while it was tape-selected, `tape_ready` becomes 1 if `tape_len`>0.
- **FSM states:** IDLE, WR, RD_WAIT, RD_DONE.
  - **IDLE, hold valid:** go to WR. Drive `sram_addr`/`sram_din` from the hold register, set `sram_we`=1, clear hold valid.
  - **IDLE, else if `rd_req` & `tape_ready`:**
    - If `rd_addr` ≥ `tape_len`: stay in IDLE and pulse `rd_ack` with `rd_eot`=1 and `rd_data`=0x00. No SRAM access.
    - Otherwise: drive `sram_addr`=`rd_addr`, set `sram_we`=0, load the latency counter with `SRAM_LAT`, and go to RD_WAIT.
  - **IDLE, `rd_req` while `tape_ready`=0:** the request stays pending. No ack is given until a tape is ready.
  - **WR:** deassert `sram_we` and return to IDLE. Each write occupies exactly one SRAM cycle.
  - **RD_WAIT:** decrement the counter. When it reaches 0, go to RD_DONE.
  - **RD_DONE:** capture `sram_dout` into `rd_data`, pulse `rd_ack` with `rd_eot`=0, and return to IDLE.
- **Write arriving during a read.** A loader write that arrives while a read is in RD_WAIT or RD_DONE is held. The read completes with valid data, then the write is issued.
- **Ack/request handshake.** `rd_ack` is never asserted in two consecutive cycles. A requester that keeps `rd_req` high after its ack is treated as issuing a new request in the cycle after the ack.

## Timing
- **Reset values:** all outputs 0 (`rd_data`=0x00, `tape_len`=0, `sram_addr`=0); state is IDLE and hold valid is 0.
- **Write latency:** `ioctl_wr` in cycle N produces `sram_we`=1 in cycle N+2 (capture, then issue), provided the FSM is in IDLE at N+1.
- **Read latency, SRAM hit:** `rd_req` sampled in IDLE at cycle N gives `sram_addr` valid at N+1 and `rd_ack` at N+2+`SRAM_LAT`. With the default that is 3 cycles.
- **Read latency, EOT:** `rd_ack` and `rd_eot` at N+1.
- **Priority:** when hold-valid and `rd_req` are both present in IDLE, the write goes first. The read starts at the earliest in the cycle after WR.
- **Reset mid-operation:** an in-flight read is abandoned with no `rd_ack`, and the hold register is dropped.

## Test plan
- **Basic load:** download 4 bytes 0x11,0x22,0x33,0x44 at 0..3 with `ioctl_wr` every 8 cycles. Expect `sram_we` pulses at addresses 0..3, `tape_len`=4, and `tape_ready`=1 one cycle after the download falls.
- **Read hit:** `rd_req` with `rd_addr`=2. Expect `rd_ack` exactly 3 cycles later with `rd_data`=0x33 and `rd_eot`=0, and a single ack.
- **EOT:** `rd_addr`=4 with `tape_len`=4. Expect `rd_ack` the next cycle with `rd_eot`=1, `rd_data`=0x00, and no new `sram_addr` issued.
- **Collision:** start a read, then pulse `ioctl_wr` (load_sel, address 0x10, 0xAA) one cycle later. Expect the read to ack with correct data, then `sram_we` at 0x10 with 0xAA, and `wr_overrun`=0.
- **Bounds:** write at `ioctl_addr`=0x10000 sets `wr_overrun` and leaves `tape_len` unchanged. Write at 0xFFFF gives `tape_len`=65536. Two `ioctl_wr` pulses in consecutive cycles set `wr_overrun`.
- **Reset:** drop `COCO_RESET_N` while in RD_WAIT. Expect all outputs 0 immediately (asynchronously), and no `rd_ack` after release until a new load completes.
